// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM encoding, word geometry and checksum width.
package loader_pkg;

    // Loader FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    // Image bytes per 32-bit word (MSB byte first on the wire).
    localparam int BYTES_PER_WORD = 4;

    // Width of the length, instruction and checksum words.
    localparam int CSUM_WIDTH = 32;

    // True in the states where the loader consumes image bytes.
    function automatic logic accepts_bytes(input loader_state_t st);
        return (st == ST_LEN) || (st == ST_DATA) || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: the environment side (byte source, memory sink).
// slave : the loader itself.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            in_byte;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_byte,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_byte,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader_assembler.sv
// Byte-to-word assembler: a 2-bit byte counter plus a shift register
// holding the first three bytes of the current word. The fourth byte is
// merged combinationally, so word_valid pulses in the same cycle the last
// byte is accepted and the caller can register the result directly.
module byte_word_assembler
    import loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  word_valid,
    output logic [CSUM_WIDTH-1:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // Next counter / shift contents; counter wraps to 0 at each word boundary.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_in};
        end
    end

    // Counter and shift register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid = byte_valid && !clear && (cnt_q == LAST_BYTE);
    assign word       = {shift_q, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Consumes a length word, N
// instruction words and a checksum word from a byte stream, writes the
// instructions into instruction memory and releases the CPU from reset
// only after the checksum matches.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_reset,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] words_loaded
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    // Largest legal N is the full memory capacity.
    localparam logic [CSUM_WIDTH:0]   CAPACITY = (CSUM_WIDTH + 1)'(1) << ADDR_WIDTH;

    loader_state_t              state_q, state_d;
    logic [ADDR_WIDTH:0]        n_q, n_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [ADDR_WIDTH:0]        count_q, count_d;
    logic [CSUM_WIDTH-1:0]      sum_q, sum_d;
    logic                       mem_we_q, mem_we_d;
    logic [31:0]                mem_wdata_q, mem_wdata_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;
    logic                       cpu_reset_q, cpu_reset_d;

    logic                       in_ready_c;
    logic                       accept;
    logic                       restart;
    logic                       word_valid;
    logic [CSUM_WIDTH-1:0]      word;

    assign in_ready_c = accepts_bytes(state_q);
    assign accept     = bus.in_valid && in_ready_c;
    // start is honoured only outside an active load.
    assign restart    = start && !in_ready_c;

    byte_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (accept),
        .byte_in    (bus.in_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    // Next-state logic, write scheduling and running checksum.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        addr_d      = addr_q;
        count_d     = count_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        // The write cycle itself advances address, count and sum.
        if (mem_we_q) begin
            addr_d  = addr_q + ADDR_ONE;
            count_d = count_q + CNT_ONE;
            sum_d   = sum_q + mem_wdata_q;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN;
                    n_d     = '0;
                    addr_d  = BASE;
                    count_d = '0;
                    sum_d   = '0;
                end
            end
            ST_LEN: begin
                if (word_valid) begin
                    n_d = word[ADDR_WIDTH:0];
                    if ({1'b0, word} > CAPACITY) begin
                        state_d = ST_ERROR;
                    end else if (word == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = word;
                    // Earlier writes have already landed in count_q here.
                    if (count_q + CNT_ONE == n_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                // sum_d folds in a write still pending this cycle.
                if (word_valid) begin
                    state_d = (word == sum_d) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
        cpu_reset_d = (state_d != ST_DONE);
    end

    // State and output registers; asynchronous reset aborts any load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            addr_q      <= BASE;
            count_q     <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_loaded  = count_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time loader upstream of the single-cycle CPU. Receives a program image as a byte stream with a valid/ready handshake.
- Assembles the bytes into 32-bit instruction words and writes them into instruction memory through its write port.
- Holds the CPU in reset until the image is fully written and its checksum verifies.
- Replaces the `$readmemh` preload, so benches and hardware share one boot path.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.
- BASE_ADDR, 0, word address of the first instruction written.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load
- in_byte  in  8  image byte
- in_valid  in  1  in_byte valid
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  ADDR_WIDTH  instruction-memory word address
- mem_wdata  out  32  instruction word to write
- cpu_reset  out  1  reset driven to the CPU
- done  out  1  image loaded and verified
- error  out  1  load failed
- words_loaded  out  ADDR_WIDTH+1  count of words written in this load

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted:
  - state = IDLE
  - cpu_reset = 1
  - in_ready, mem_we, done, error = 0
  - mem_addr = BASE_ADDR, mem_wdata = 0, words_loaded = 0
  - Memory already written is not erased.
- Image format:
  - A 32-bit length word N, then N instruction words, then a 32-bit checksum word.
  - Every word is sent MSB byte first.
  - Checksum = sum of the N instruction words mod 2^32.
- Handshake:
  - A byte transfers on a rising edge where in_valid and in_ready are both 1.
  - in_ready = 1 only in states LEN, DATA, CSUM; otherwise 0.
  - in_valid may drop at any time; gaps do not change results.
- A 2-bit byte counter and a 32-bit shift register assemble each word. The counter resets at each word boundary.
- FSM states:
  - IDLE:
    - Outputs at reset values.
    - start → LEN; byte counter and running sum cleared, words_loaded = 0, mem_addr = BASE_ADDR.
  - LEN: after the 4th byte, latch N. Next state is chosen by N:
    - N > 2**ADDR_WIDTH → ERROR.
    - N == 0 → CSUM.
    - Otherwise → DATA.
  - DATA:
    - Cycle after the 4th byte of a word: mem_we = 1 for exactly one cycle, with mem_addr = current address and mem_wdata = assembled word.
    - That same cycle: address += 1 (wraps modulo 2**ADDR_WIDTH), words_loaded += 1, sum += word.
    - After the Nth word is accepted → CSUM.
    - A byte may be accepted in the same cycle mem_we pulses, so back-to-back streaming runs at 1 byte per cycle.
  - CSUM: after the 4th byte, compare with the running sum, which already includes the final word's write cycle.
    - Match → DONE.
    - Mismatch → ERROR.
  - DONE:
    - done = 1 and cpu_reset = 0, both registered. They take effect in the cycle after the last checksum byte is accepted, or after the final write if that is later.
    - The CPU therefore starts fetching from pc 0 on the next edge.
  - ERROR:
    - error = 1, cpu_reset = 1, in_ready = 0.
    - Sticky until start or reset.
- start handling:
  - start in DONE or ERROR: cpu_reset = 1, done = 0, error = 0, then → LEN.
  - start in LEN, DATA or CSUM is ignored.
- Extra bytes offered in DONE, ERROR or IDLE are not accepted, because in_ready = 0.
- Reset asserted mid-load aborts the load immediately. A fresh start is required afterwards.

Decomposition:
- Shared package `loader_pkg`:
  - FSM state encoding (IDLE, LEN, DATA, CSUM, DONE, ERROR, 3 bits).
  - Byte-per-word constant (4).
  - Checksum width (32).
- One natural sub-module, `byte_word_assembler`:
  - Byte counter plus shift register.
  - Emits a word_valid pulse and the assembled word.
  - Has a clear input used at state entry.

Test Plan:
1. start; stream N=2, 0x20080005, 0x20090003, checksum 0x40110008 with in_valid held high → mem_we pulses at addr 0 then addr 1 with those words; done=1, cpu_reset=0, words_loaded=2, error=0.
2. Same image with checksum 0x00000000 → both writes occur; error=1, cpu_reset stays 1, done=0, in_ready=0.
3. N=0, checksum 0x00000000 → no mem_we pulses; done=1, cpu_reset=0, words_loaded=0.
4. N=1025 with ADDR_WIDTH=10 → error=1 the cycle after the 4th length byte; no mem_we; in_ready=0.
5. Scenario 1 with 0–3 random idle cycles between bytes, then start again from DONE with a 1-word image 0x00000020 and checksum 0x00000020 → first load identical to scenario 1. On the restart: cpu_reset rises on start, one write at addr 0, done again.
6. Assert reset after 6 bytes of scenario 1 (mid-DATA) → all outputs return to reset values without waiting for a clock edge. Then start plus the full scenario 1 stream → passes as in scenario 1.
